// File: rtl/l2_cache_assoc.sv
// N-way set-associative, write-back, write-allocate L2 cache with true-LRU age replacement.
// Optional performance counters (acc_cnt, miss_cnt) are built when L2_PERF_CNT_EN is defined.
module l2_cache_assoc #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned SETS   = 16,
  parameter int unsigned WAYS   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata,
  output logic              ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]       acc_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned AGE_W = $clog2(WAYS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t             r_state;
  logic [AGE_W-1:0]   r_victim;
  logic [WAYS-1:0]    r_valid [SETS];
  logic [WAYS-1:0]    r_dirty [SETS];
  logic [AGE_W-1:0]   r_age   [SETS][WAYS];
  logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
  logic [LINE_W-1:0]  r_data  [SETS][WAYS];

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic [AGE_W-1:0]   w_hit_way;
  logic               w_inv_found;
  logic [AGE_W-1:0]   w_inv_way;
  logic [AGE_W-1:0]   w_lru_way;
  logic [AGE_W-1:0]   w_victim;
  logic               w_fill;
  logic               w_wr_hit;

  assign w_idx = addr[IDX_W-1:0];
  assign w_tag = addr[ADDR_W-1:IDX_W];

  // Tag match plus victim choice: lowest invalid way first, otherwise the oldest way.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag) && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(w);
      end
      if (!r_valid[w_idx][w] && !w_inv_found) begin
        w_inv_found = 1'b1;
        w_inv_way   = AGE_W'(w);
      end
      if (r_age[w_idx][w] == AGE_W'(WAYS-1)) w_lru_way = AGE_W'(w);
    end
    w_victim = w_inv_found ? w_inv_way : w_lru_way;
  end

  assign w_fill   = (r_state == S_ALLOCATE) && mem_read && mem_ready;
  assign w_wr_hit = (r_state == S_COMPARE) && w_hit && write;

  // Line storage carries no reset; validity lives in r_valid.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_idx][r_victim] <= mem_rdata;
      r_tag[w_idx][r_victim]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_idx][w_hit_way] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_victim  <= '0;
      ready     <= 1'b0;
      rdata     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= AGE_W'(w);
      end
    end else begin
      ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if ((read || write) && !ready) r_state <= S_COMPARE;
        end
        S_COMPARE: begin
          if (w_hit) begin
            ready <= 1'b1;
            if (write) r_dirty[w_idx][w_hit_way] <= 1'b1;
            else       rdata <= r_data[w_idx][w_hit_way];
            // Ways younger than the hit way age by one; the hit way becomes youngest.
            for (int w = 0; w < WAYS; w++) begin
              if (r_age[w_idx][w] < r_age[w_idx][w_hit_way])
                r_age[w_idx][w] <= r_age[w_idx][w] + AGE_W'(1);
            end
            r_age[w_idx][w_hit_way] <= '0;
            r_state <= S_IDLE;
          end else begin
            r_victim <= w_victim;
            if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
              mem_write <= 1'b1;
              mem_addr  <= {r_tag[w_idx][w_victim], w_idx};
              mem_wdata <= r_data[w_idx][w_victim];
              r_state   <= S_WRITEBACK;
            end else begin
              r_state <= S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            mem_write                <= 1'b0;
            r_dirty[w_idx][r_victim] <= 1'b0;
            r_state                  <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          // First cycle here only raises mem_read, which also gives the gap after a writeback.
          if (!mem_read) begin
            mem_read <= 1'b1;
            mem_addr <= addr;
          end else if (mem_ready) begin
            mem_read                 <= 1'b0;
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= 1'b0;
            r_state                  <= S_COMPARE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef L2_PERF_CNT_EN
  // Saturating access and miss counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && (read || write) && !ready && (acc_cnt != 32'hFFFF_FFFF))
        acc_cnt <= acc_cnt + 32'd1;
      if ((r_state == S_COMPARE) && !w_hit && (miss_cnt != 32'hFFFF_FFFF))
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache_assoc.sv
// Randomised bench for l2_cache_assoc against a recency-list cache model and a 3-cycle memory.
module tb_l2_cache_assoc;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned SETS   = 16;
  localparam int unsigned WAYS   = 4;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned TAG_W  = ADDR_W - IDX_W;

  logic              clk;
  logic              reset;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
`ifdef L2_PERF_CNT_EN
  logic [31:0]       acc_cnt;
  logic [31:0]       miss_cnt;
`endif

  l2_cache_assoc #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef L2_PERF_CNT_EN
    , .acc_cnt(acc_cnt), .miss_cnt(miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] init_line(input logic [ADDR_W-1:0] a);
    return {4{4'h5, a}};
  endfunction

  // Main memory as seen by the DUT and as predicted by the model.
  logic [LINE_W-1:0] dut_mem   [logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] model_mem [logic [ADDR_W-1:0]];

  bit                q_wr   [$];
  logic [ADDR_W-1:0] q_addr [$];
  logic [LINE_W-1:0] q_data [$];

  // Memory responder: completes each access 3 cycles after it is raised.
  int unsigned rsp_cnt;
  bit          rsp_done;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    rsp_cnt   = 0;
    rsp_done  = 1'b0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!reset || !(mem_read || mem_write)) begin
        rsp_cnt  = 0;
        rsp_done = 1'b0;
      end else if (!rsp_done) begin
        rsp_cnt++;
        if (rsp_cnt == 3) begin
          mem_ready = 1'b1;
          rsp_done  = 1'b1;
          q_wr.push_back(mem_write);
          q_addr.push_back(mem_addr);
          if (mem_write) begin
            dut_mem[mem_addr] = mem_wdata;
            q_data.push_back(mem_wdata);
          end else begin
            mem_rdata = dut_mem.exists(mem_addr) ? dut_mem[mem_addr] : init_line(mem_addr);
            q_data.push_back(mem_rdata);
          end
        end
      end
    end
  end

  int both_cnt = 0;
  int gap_cnt  = 0;
  bit prev_w   = 1'b0;
  initial forever begin
    @(negedge clk);
    if (mem_read && mem_write) both_cnt++;
    if (prev_w && mem_read) gap_cnt++;
    prev_w = mem_write;
  end

  // Reference model: per set, lines kept in recency order, index 0 most recent.
  int                m_cnt   [SETS];
  logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data  [SETS][WAYS];
  bit                m_dirty [SETS][WAYS];

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
  endtask

  task automatic move_front(input int s, input int pos);
    logic [TAG_W-1:0]  t;
    logic [LINE_W-1:0] d;
    bit                dy;
    t = m_tag[s][pos]; d = m_data[s][pos]; dy = m_dirty[s][pos];
    for (int i = pos; i > 0; i--) begin
      m_tag[s][i] = m_tag[s][i-1]; m_data[s][i] = m_data[s][i-1]; m_dirty[s][i] = m_dirty[s][i-1];
    end
    m_tag[s][0] = t; m_data[s][0] = d; m_dirty[s][0] = dy;
  endtask

  task automatic do_req(input string name, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [LINE_W-1:0] d);
    int                s;
    logic [TAG_W-1:0]  t;
    int                pos;
    bit                exp_hit;
    bit                exp_wb;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_data;
    logic [LINE_W-1:0] exp_line;
    int                cyc;
    bit                got_ready;
    int                k;
    s = int'(a[IDX_W-1:0]);
    t = a[ADDR_W-1:IDX_W];
    pos = -1;
    exp_wb = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    for (int i = 0; i < m_cnt[s]; i++) if (pos < 0 && m_tag[s][i] == t) pos = i;
    exp_hit = (pos >= 0);
    if (exp_hit) begin
      move_front(s, pos);
    end else begin
      if (m_cnt[s] == WAYS) begin
        if (m_dirty[s][WAYS-1]) begin
          exp_wb  = 1'b1;
          wb_addr = {m_tag[s][WAYS-1], a[IDX_W-1:0]};
          wb_data = m_data[s][WAYS-1];
          model_mem[wb_addr] = wb_data;
        end
        m_cnt[s]--;
      end
      for (int i = m_cnt[s]; i > 0; i--) begin
        m_tag[s][i] = m_tag[s][i-1]; m_data[s][i] = m_data[s][i-1]; m_dirty[s][i] = m_dirty[s][i-1];
      end
      m_tag[s][0]   = t;
      m_data[s][0]  = model_mem.exists(a) ? model_mem[a] : init_line(a);
      m_dirty[s][0] = 1'b0;
      m_cnt[s]++;
    end
    if (wr) begin
      m_data[s][0]  = d;
      m_dirty[s][0] = 1'b1;
    end
    exp_line = m_data[s][0];

    q_wr.delete(); q_addr.delete(); q_data.delete();
    read = !wr; write = wr; addr = a; wdata = d;
    cyc = 0;
    got_ready = 1'b0;
    while (!got_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (ready) got_ready = 1'b1;
    end
    check({name, "_ready"}, LINE_W'(got_ready), LINE_W'(1));
    if (got_ready && !wr) check({name, "_rdata"}, rdata, exp_line);
    read = 1'b0; write = 1'b0;
    if (exp_hit) check({name, "_hit_latency"}, LINE_W'(cyc), LINE_W'(2));
    check({name, "_mem_txns"}, LINE_W'(q_wr.size()), LINE_W'(exp_hit ? 0 : (exp_wb ? 2 : 1)));
    if (!exp_hit && q_wr.size() == (exp_wb ? 2 : 1)) begin
      k = 0;
      if (exp_wb) begin
        check({name, "_wb_kind"}, LINE_W'(q_wr[0]), LINE_W'(1));
        check({name, "_wb_addr"}, LINE_W'(q_addr[0]), LINE_W'(wb_addr));
        check({name, "_wb_data"}, q_data[0], wb_data);
        k = 1;
      end
      check({name, "_rd_kind"}, LINE_W'(q_wr[k]), LINE_W'(0));
      check({name, "_rd_addr"}, LINE_W'(q_addr[k]), LINE_W'(a));
    end
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ready"},     LINE_W'(ready),     LINE_W'(0));
    check({name, "_rdata"},     rdata,              LINE_W'(0));
    check({name, "_mem_read"},  LINE_W'(mem_read),  LINE_W'(0));
    check({name, "_mem_write"}, LINE_W'(mem_write), LINE_W'(0));
    check({name, "_mem_addr"},  LINE_W'(mem_addr),  LINE_W'(0));
    check({name, "_mem_wdata"}, mem_wdata,          LINE_W'(0));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    read = 1'b0; write = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [LINE_W-1:0] DEAD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  initial begin
    int  seen;
    bit  wr;
    logic [ADDR_W-1:0] a;
    reset = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    model_clear();
    #1;
    check_outputs_zero("por");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Read miss then read hit.
    do_req("t1_miss", 1'b0, 28'h0000010, '0);
    do_req("t1_hit",  1'b0, 28'h0000010, '0);

    // Write hit then eviction of the dirty line.
    do_req("t2_fill", 1'b0, 28'h0000020, '0);
    do_req("t2_wr",   1'b1, 28'h0000020, DEAD);
    do_req("t2_f30",  1'b0, 28'h0000030, '0);
    do_req("t2_f40",  1'b0, 28'h0000040, '0);
    do_req("t2_f50",  1'b0, 28'h0000050, '0);
    do_req("t2_evict",1'b0, 28'h0000060, '0);
    do_req("t2_back", 1'b0, 28'h0000020, '0);

    // LRU order within one set.
    apply_reset();
    do_req("t3_f00", 1'b0, 28'h0000000, '0);
    do_req("t3_f10", 1'b0, 28'h0000010, '0);
    do_req("t3_f20", 1'b0, 28'h0000020, '0);
    do_req("t3_f30", 1'b0, 28'h0000030, '0);
    do_req("t3_r00", 1'b0, 28'h0000000, '0);
    do_req("t3_f40", 1'b0, 28'h0000040, '0);
`ifdef L2_PERF_CNT_EN
    check("t6_acc_cnt",  LINE_W'(acc_cnt),  LINE_W'(6));
    check("t6_miss_cnt", LINE_W'(miss_cnt), LINE_W'(5));
`endif
    do_req("t3_r00b", 1'b0, 28'h0000000, '0);

    // All ways of set 5 dirty, then a new tag.
    for (int i = 0; i < 4; i++)
      do_req("t4_wr", 1'b1, ADDR_W'(i * SETS + 5), {$urandom, $urandom, $urandom, $urandom});
    do_req("t4_new", 1'b0, 28'h0000045, '0);

    // Reset while a refill is outstanding.
    do_req("t5_pre", 1'b0, 28'h0000010, '0);
    read = 1'b1; addr = 28'h0000077;
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      @(negedge clk);
      if (mem_read) seen = 1;
    end
    check("t5_mem_read_seen", LINE_W'(seen), LINE_W'(1));
    reset = 1'b0;
    read = 1'b0;
    #1;
    check_outputs_zero("t5_midreset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    do_req("t5_after", 1'b0, 28'h0000010, '0);

    // Randomised traffic over a few sets and tags.
    for (int n = 0; n < 250; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ADDR_W'($urandom_range(0, 5) * SETS + $urandom_range(0, 3));
      do_req("rnd", wr, a, {$urandom, $urandom, $urandom, $urandom});
    end

    check("rw_exclusive", LINE_W'(both_cnt), LINE_W'(0));
    check("wb_refill_gap", LINE_W'(gap_cnt), LINE_W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
